// File: rtl/apb4_master_bridge.sv
// APB4 master bridge: turns single-beat valid/ready requests into APB4
// SETUP/ACCESS transfers, with a bounded-wait watchdog and a one-cycle
// response pulse carrying read data and error/timeout status.
module apb4_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [3:0]            req_wstrb_i,
  input  logic [2:0]            req_prot_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  rsp_timeout_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [2:0]            pprot_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  output logic [3:0]            pstrb_o,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i
);

  // Counter only needs to reach TIMEOUT_CYCLES-1; keep at least one bit.
  localparam int              CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit              WDOG_EN  = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [3:0]              wstrb_q;
  logic [2:0]              prot_q;
  logic                    pwrite_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    err_q;
  logic                    timeout_q;
  logic                    accept;
  logic                    timeout_hit;

  assign accept      = (state_q == ST_IDLE) && req_valid_i;
  // pready wins over the watchdog when both land on the same edge.
  assign timeout_hit = WDOG_EN && (state_q == ST_ACCESS) && !pready_i && (cnt_q == CNT_LAST);

  // Next-state logic for the transfer sequencer.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (req_valid_i) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (pready_i || timeout_hit) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register; reset aborts any transfer in flight without a response.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Watchdog: counts ACCESS cycles, cleared everywhere else.
  always_ff @(posedge clk_i) begin
    if (rst_i)                    cnt_q <= '0;
    else if (state_q == ST_ACCESS) cnt_q <= cnt_q + CNT_W'(1);
    else                          cnt_q <= '0;
  end

  // Request capture at accept; held stable for the whole APB transfer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      prot_q   <= '0;
      pwrite_q <= 1'b0;
    end else if (accept) begin
      addr_q   <= req_addr_i;
      wdata_q  <= req_wdata_i;
      wstrb_q  <= req_wstrb_i;
      prot_q   <= req_prot_i;
      pwrite_q <= |req_wstrb_i;
    end
  end

  // Response capture at the end of ACCESS (completion or watchdog abort).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q   <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else if (state_q == ST_ACCESS && pready_i) begin
      rdata_q   <= (pwrite_q || pslverr_i) ? '0 : prdata_i;
      err_q     <= pslverr_i;
      timeout_q <= 1'b0;
    end else if (timeout_hit) begin
      rdata_q   <= '0;
      err_q     <= 1'b1;
      timeout_q <= 1'b1;
    end
  end

  // Outputs decode only flopped state, so APB inputs never reach them combinationally.
  assign req_ready_o   = (state_q == ST_IDLE);
  assign psel_o        = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign penable_o     = (state_q == ST_ACCESS);
  assign paddr_o       = addr_q;
  assign pprot_o       = prot_q;
  assign pwrite_o      = pwrite_q;
  assign pwdata_o      = wdata_q;
  assign pstrb_o       = wstrb_q;
  assign rsp_valid_o   = (state_q == ST_RESP);
  assign rsp_rdata_o   = rsp_valid_o ? rdata_q : '0;
  assign rsp_err_o     = rsp_valid_o & err_q;
  assign rsp_timeout_o = rsp_valid_o & timeout_q;

endmodule

// File: tb/tb_apb4_master_bridge.sv
// Self-checking bench for apb4_master_bridge: a responsive APB slave with
// programmable wait states, and an expected-response model computed from
// the transfer rules (latency, data masking, watchdog bound).
module tb_apb4_master_bridge;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic [2:0]  req_prot;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] paddr;
  logic [2:0]  pprot;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int checks = 0;
  int errors = 0;

  apb4_master_bridge #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .req_wstrb_i  (req_wstrb),
    .req_prot_i   (req_prot),
    .rsp_valid_o  (rsp_valid),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err),
    .rsp_timeout_o(rsp_timeout),
    .paddr_o      (paddr),
    .pprot_o      (pprot),
    .psel_o       (psel),
    .penable_o    (penable),
    .pwrite_o     (pwrite),
    .pwdata_o     (pwdata),
    .pstrb_o      (pstrb),
    .prdata_i     (prdata),
    .pready_i     (pready),
    .pslverr_i    (pslverr)
  );

  always #5 clk = ~clk;

  // One request through a slave that raises pready on ACCESS cycle `waits`
  // (0-based); waits >= TMO means the slave never answers in time.
  // Called at posedge+1 with the bridge idle; returns at posedge+1, idle again.
  task automatic run_txn(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [2:0] prot, input int waits,
                         input logic slv_err, input logic [31:0] slv_data);
    logic        is_wr    = |wstrb;
    logic        exp_to   = (waits >= TMO);
    int          exp_edge = exp_to ? (1 + TMO) : (2 + waits);
    int          exp_acc  = exp_to ? TMO : (waits + 1);
    logic        exp_err  = exp_to ? 1'b1 : slv_err;
    logic [31:0] exp_rd   = (is_wr || exp_to || slv_err) ? 32'h0 : slv_data;
    logic [71:0] exp_apb  = {addr, wdata, wstrb, prot, is_wr};
    int          setup_n  = 0;
    int          acc_n    = 0;
    int          rsp_edge = -1;

    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s idle_ready: got %b want 1", name, req_ready);
    end
    req_valid = 1'b1;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = wstrb;
    req_prot  = prot;
    @(posedge clk); #1;
    // Scramble the request bus: the bridge must be working from its own copy.
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_wstrb = 4'($urandom);
    req_prot  = 3'($urandom);

    for (int n = 1; n <= 40 && rsp_edge < 0; n++) begin
      checks++;
      if (req_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s busy_ready: cycle %0d got %b want 0", name, n, req_ready);
      end
      if (psel) begin
        checks++;
        if ({paddr, pwdata, pstrb, pprot, pwrite} !== exp_apb) begin
          errors++;
          $display("FAIL %s apb_fields: cycle %0d got %h want %h", name, n,
                   {paddr, pwdata, pstrb, pprot, pwrite}, exp_apb);
        end
      end
      if (psel && !penable) setup_n++;
      if (psel && penable) begin
        pready  = (acc_n == waits);
        pslverr = pready ? slv_err : 1'($urandom);
        prdata  = pready ? slv_data : $urandom;
        acc_n++;
      end else begin
        pready  = 1'($urandom);
        pslverr = 1'($urandom);
        prdata  = $urandom;
      end
      @(posedge clk); #1;
      pready  = 1'b0;
      pslverr = 1'b0;
      if (rsp_valid) begin
        rsp_edge = n;
        checks++;
        if ({rsp_rdata, rsp_err, rsp_timeout} !== {exp_rd, exp_err, exp_to}) begin
          errors++;
          $display("FAIL %s rsp: got rdata=%h err=%b to=%b want rdata=%h err=%b to=%b",
                   name, rsp_rdata, rsp_err, rsp_timeout, exp_rd, exp_err, exp_to);
        end
        checks++;
        if (psel !== 1'b0 || penable !== 1'b0) begin
          errors++;
          $display("FAIL %s resp_bus: psel=%b penable=%b want 0 0", name, psel, penable);
        end
      end else begin
        checks++;
        if ({rsp_rdata, rsp_err, rsp_timeout} !== 34'h0) begin
          errors++;
          $display("FAIL %s rsp_idle: got %h want 0", name, {rsp_rdata, rsp_err, rsp_timeout});
        end
      end
    end

    checks++;
    if (rsp_edge !== exp_edge) begin
      errors++;
      $display("FAIL %s latency: rsp at edge %0d want %0d", name, rsp_edge, exp_edge);
    end
    checks++;
    if (setup_n !== 1 || acc_n !== exp_acc) begin
      errors++;
      $display("FAIL %s phases: setup=%0d access=%0d want 1 %0d", name, setup_n, acc_n, exp_acc);
    end

    @(posedge clk); #1;
    checks++;
    if ({req_ready, rsp_valid, psel} !== 3'b100) begin
      errors++;
      $display("FAIL %s back_idle: ready/rsp/psel=%b want 100", name, {req_ready, rsp_valid, psel});
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'hFFFF_FFFF;
    req_wstrb = 4'hF;
    req_prot  = 3'h7;
    prdata    = 32'hFFFF_FFFF;
    pready    = 1'b1;
    pslverr   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = 1'b0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    checks++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, paddr, pprot, psel,
         penable, pwrite, pwdata, pstrb} !== {1'b1, 109'h0}) begin
      errors++;
      $display("FAIL reset_outputs: got %h want %h",
               {req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, paddr, pprot, psel,
                penable, pwrite, pwdata, pstrb}, {1'b1, 109'h0});
    end
  endtask

  task automatic test_zero_wait_read();
    run_txn("zero_wait_read", 32'h0000_0010, 32'h0, 4'h0, 3'h0, 0, 1'b0, 32'hDEAD_BEEF);
  endtask

  task automatic test_write_waits();
    run_txn("write_2wait", 32'h0000_0200, 32'h1234_5678, 4'h3, 3'h2, 2, 1'b0, 32'hCAFE_F00D);
  endtask

  task automatic test_slave_error();
    run_txn("slave_error", 32'h0000_0044, 32'h0, 4'h0, 3'h1, 1, 1'b1, 32'hFFFF_FFFF);
  endtask

  task automatic test_timeout();
    run_txn("timeout", 32'h0000_0300, 32'h0, 4'h0, 3'h0, 1000, 1'b0, 32'h5555_AAAA);
    run_txn("after_timeout", 32'h0000_0304, 32'h0, 4'h0, 3'h0, 0, 1'b0, 32'h0BAD_CAFE);
  endtask

  task automatic test_boundary();
    run_txn("boundary_read", 32'h0000_0400, 32'h0, 4'h0, 3'h3, TMO - 1, 1'b0, 32'h8765_4321);
    run_txn("boundary_write", 32'h0000_0404, 32'hA5A5_5A5A, 4'hF, 3'h0, TMO - 1, 1'b1, 32'h1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic [3:0] ws = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      run_txn("random", $urandom, $urandom, ws, 3'($urandom), int'($urandom_range(0, 5)),
              ($urandom_range(0, 3) == 0), $urandom);
    end
  endtask

  task automatic test_reset_mid_access();
    int stray = 0;
    req_valid = 1'b1;
    req_addr  = 32'h0000_0500;
    req_wstrb = 4'h0;
    req_prot  = 3'h0;
    pready    = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    checks++;
    if (penable !== 1'b1) begin
      errors++;
      $display("FAIL mid_access_setup: penable=%b want 1", penable);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({psel, penable, req_ready, rsp_valid, paddr} !== {4'b0010, 32'h0}) begin
      errors++;
      $display("FAIL mid_access_reset: psel/pen/ready/rsp=%b paddr=%h want 0010 0",
               {psel, penable, req_ready, rsp_valid}, paddr);
    end
    for (int i = 0; i < 6; i++) begin
      pready  = 1'($urandom);
      pslverr = 1'($urandom);
      @(posedge clk); #1;
      if (rsp_valid || psel) stray++;
    end
    pready  = 1'b0;
    pslverr = 1'b0;
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL mid_access_stray: %0d cycles with rsp_valid/psel, want 0", stray);
    end
    run_txn("after_reset", 32'h0000_0508, 32'h0, 4'h0, 3'h0, 1, 1'b0, 32'h0F0F_0F0F);
  endtask

  task automatic test_back_to_back();
    int          accepts[$];
    logic [31:0] rd_exp[$];
    int          rsps = 0;
    int          bad  = 0;
    req_valid = 1'b1;
    req_wstrb = 4'h0;
    req_prot  = 3'h0;
    for (int e = 0; e < 12; e++) begin
      req_addr = $urandom;
      if (req_ready) accepts.push_back(e);
      pready  = psel && penable;
      pslverr = 1'b0;
      prdata  = $urandom;
      if (pready) rd_exp.push_back(prdata);
      @(posedge clk); #1;
      if (rsp_valid) begin
        rsps++;
        if (rd_exp.size() == 0 || rsp_rdata !== rd_exp.pop_front() || rsp_err) bad++;
      end
    end
    req_valid = 1'b0;
    pready    = 1'b0;
    checks++;
    if (accepts.size() !== 3 || rsps !== 3) begin
      errors++;
      $display("FAIL b2b_count: accepts=%0d rsps=%0d want 3 3", accepts.size(), rsps);
    end else begin
      checks++;
      if (accepts[1] - accepts[0] !== 4 || accepts[2] - accepts[1] !== 4) begin
        errors++;
        $display("FAIL b2b_spacing: accepts at %0d %0d %0d want spacing 4",
                 accepts[0], accepts[1], accepts[2]);
      end
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL b2b_data: %0d bad responses want 0", bad);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_zero_wait_read();
    test_write_waits();
    test_slave_error();
    test_timeout();
    test_boundary();
    test_random();
    test_reset_mid_access();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
